// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: internal instruction ROM, data RAM and register file.
// Define RV_FULL_BRANCH_EN to also execute blt/bge/bltu/bgeu.

module rv_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] RF [0:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) RF[i] <= '0;
      end else if (we && wa != 5'd0) begin
         RF[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : RF[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : RF[ra2];
endmodule

module rv_imem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic [AW-1:0] addr,
   output logic [31:0]   data
);
   // Loaded from outside through the hierarchy; never written by the core.
   logic [31:0] instruction_memory [0:DEPTH-1];

   assign data = instruction_memory[addr];
endmodule

module rv_dmem #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] data_memory [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) data_memory[addr] <= wdata;
   end

   assign rdata = data_memory[addr];
endmodule

module rv32i_single_cycle_core #(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
) (
   input logic clk,
   input logic n_rst
);
   localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
   localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_ST  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JR  = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;

   logic [31:0]    PC, instr, pc4, pc_next;
   logic [31:0]    rs1_v, rs2_v, wb_data, dm_rdata, ls_addr;
   logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [6:0]     opcode, f7;
   logic [2:0]     f3;
   logic           rf_we, dm_we, taken, r_ok, i_ok;
   logic [IAW-1:0] iaddr;
   logic [DAW-1:0] daddr;

   function automatic logic [31:0] alu(
      input logic [2:0]  op,
      input logic        alt,
      input logic [31:0] a,
      input logic [31:0] b
   );
      case (op)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[4:0];
         3'd2:    return {31'd0, $signed(a) < $signed(b)};
         3'd3:    return {31'd0, a < b};
         3'd4:    return a ^ b;
         3'd5:    return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   assign iaddr = IAW'((PC >> 2) % IMEM_DEPTH);

   rv_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) DUT_instr (
      .addr (iaddr),
      .data (instr)
   );

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];

   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};
   assign imm_u = {instr[31:12], 12'd0};
   assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                   instr[20], instr[30:21], 1'b0};

   // Only sub/sra may carry funct7=0x20; slli/srli/srai need a clean upper field.
   assign r_ok = (f7 == 7'h00) ||
                 (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
   assign i_ok = (f3 == 3'd1) ? (f7 == 7'h00) :
                 (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;

   rv_regfile DUT_RF (
      .clk (clk),
      .rst (n_rst),
      .we  (rf_we & ~n_rst),
      .ra1 (instr[19:15]),
      .ra2 (instr[24:20]),
      .wa  (instr[11:7]),
      .wd  (wb_data),
      .rd1 (rs1_v),
      .rd2 (rs2_v)
   );

   assign ls_addr = rs1_v + ((opcode == OP_ST) ? imm_s : imm_i);
   assign daddr   = DAW'((ls_addr >> 2) % DMEM_DEPTH);

   rv_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) DUT_Data (
      .clk   (clk),
      .we    (dm_we & ~n_rst),
      .addr  (daddr),
      .wdata (rs2_v),
      .rdata (dm_rdata)
   );

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000: taken = (rs1_v == rs2_v);
         3'b001: taken = (rs1_v != rs2_v);
`ifdef RV_FULL_BRANCH_EN
         3'b100: taken = ($signed(rs1_v) <  $signed(rs2_v));
         3'b101: taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110: taken = (rs1_v <  rs2_v);
         3'b111: taken = (rs1_v >= rs2_v);
`endif
         default: taken = 1'b0;
      endcase
   end

   assign pc4 = PC + 32'd4;

   always_comb begin
      pc_next = pc4;
      rf_we   = 1'b0;
      dm_we   = 1'b0;
      wb_data = '0;
      unique case (1'b1)
         opcode == OP_R: begin
            rf_we   = r_ok;
            wb_data = alu(f3, f7[5], rs1_v, rs2_v);
         end
         opcode == OP_I: begin
            rf_we   = i_ok;
            wb_data = alu(f3, (f3 == 3'd5) & f7[5], rs1_v, imm_i);
         end
         opcode == OP_LD: begin
            rf_we   = (f3 == 3'b010);
            wb_data = dm_rdata;
         end
         opcode == OP_ST: dm_we = (f3 == 3'b010);
         opcode == OP_BR: if (taken) pc_next = PC + imm_b;
         opcode == OP_JAL: begin
            rf_we   = 1'b1;
            wb_data = pc4;
            pc_next = PC + imm_j;
         end
         opcode == OP_JR: begin
            if (f3 == 3'b000) begin
               rf_we   = 1'b1;
               wb_data = pc4;
               pc_next = (rs1_v + imm_i) & ~32'd1;
            end
         end
         opcode == OP_LUI: begin
            rf_we   = 1'b1;
            wb_data = imm_u;
         end
         opcode == OP_AUI: begin
            rf_we   = 1'b1;
            wb_data = PC + imm_u;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (n_rst) PC <= '0;
      else       PC <= pc_next;
   end
endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Bench for rv32i_single_cycle_core: directed programs plus random
// programs run in lockstep with an instruction-level reference model.

module tb_rv32i_single_cycle_core;
   logic clk = 1'b0;
   logic n_rst = 1'b1;
   int   n_tests = 0;
   int   n_fail = 0;

   logic [31:0] prog [0:255];
   logic [31:0] m_rf [0:31];
   logic [31:0] m_dm [0:255];
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   rv32i_single_cycle_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
      .clk   (clk),
      .n_rst (n_rst)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int f7, input int rs2,
      input int rs1, input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_i(input int imm, input int rs1,
      input int f3, input int rd, input logic [6:0] op);
      logic [31:0] t;
      t = imm;
      return {t[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2,
      input int rs1, input int f3);
      logic [31:0] t;
      t = imm;
      return {t[11:5], 5'(rs2), 5'(rs1), 3'(f3), t[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2,
      input int rs1, input int f3);
      logic [31:0] t;
      t = imm;
      return {t[12], t[10:5], 5'(rs2), 5'(rs1), 3'(f3),
              t[4:1], t[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] t;
      t = imm;
      return {t[20], t[10:1], t[11], t[19:12], 5'(rd), 7'h6f};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm,
      input int rd, input logic [6:0] op);
      return {imm, 5'(rd), op};
   endfunction

   function automatic logic [31:0] addi(input int rd, input int rs1,
      input int imm);
      return enc_i(imm, rs1, 0, rd, 7'h13);
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = addi(0, 0, 0);
   endtask

   task automatic model_reset();
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
   endtask

   task automatic start_prog();
      @(negedge clk);
      n_rst = 1'b1;
      for (int i = 0; i < 256; i++)
         dut.DUT_instr.instruction_memory[i] = prog[i];
      @(negedge clk);
      n_rst = 1'b0;
      model_reset();
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_reg(input int r, input logic [31:0] exp);
      check($sformatf("x%0d", r), dut.DUT_RF.RF[r], exp);
   endtask

   // Executes one instruction from the architectural rules.
   task automatic model_step();
      logic [31:0] w, a, b, res, npc, ii, si, bi, ji, ui;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [4:0]  sh;
      int          rd, rs1, rs2;
      bit          wr, tk;
      w   = prog[(m_pc >> 2) % 256];
      op  = w[6:0];
      f3  = w[14:12];
      f7  = w[31:25];
      sh  = w[24:20];
      rd  = int'(w[11:7]);
      rs1 = int'(w[19:15]);
      rs2 = int'(w[24:20]);
      ii  = 32'($signed(w[31:20]));
      si  = 32'($signed({w[31:25], w[11:7]}));
      bi  = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      ji  = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
      ui  = {w[31:12], 12'h000};
      a   = m_rf[rs1];
      b   = m_rf[rs2];
      npc = m_pc + 4;
      wr  = 0;
      tk  = 0;
      res = 0;
      case (op)
         7'h33: begin
            wr = 1;
            case ({f7, f3})
               {7'h00, 3'd0}: res = a + b;
               {7'h20, 3'd0}: res = a - b;
               {7'h00, 3'd1}: res = a << b[4:0];
               {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 1 : 0;
               {7'h00, 3'd3}: res = (a < b) ? 1 : 0;
               {7'h00, 3'd4}: res = a ^ b;
               {7'h00, 3'd5}: res = a >> b[4:0];
               {7'h20, 3'd5}: res = $signed(a) >>> b[4:0];
               {7'h00, 3'd6}: res = a | b;
               {7'h00, 3'd7}: res = a & b;
               default:       wr = 0;
            endcase
         end
         7'h13: begin
            wr = 1;
            case (f3)
               3'd0: res = a + ii;
               3'd2: res = ($signed(a) < $signed(ii)) ? 1 : 0;
               3'd3: res = (a < ii) ? 1 : 0;
               3'd4: res = a ^ ii;
               3'd6: res = a | ii;
               3'd7: res = a & ii;
               3'd1: if (f7 == 0) res = a << sh; else wr = 0;
               default: begin
                  if (f7 == 7'h00)      res = a >> sh;
                  else if (f7 == 7'h20) res = $signed(a) >>> sh;
                  else                  wr = 0;
               end
            endcase
         end
         7'h03: if (f3 == 2) begin
            wr = 1;
            res = m_dm[((a + ii) >> 2) % 256];
         end
         7'h23: if (f3 == 2) m_dm[((a + si) >> 2) % 256] = b;
         7'h63: begin
            case (f3)
               3'd0: tk = (a == b);
               3'd1: tk = (a != b);
`ifdef RV_FULL_BRANCH_EN
               3'd4: tk = ($signed(a) < $signed(b));
               3'd5: tk = ($signed(a) >= $signed(b));
               3'd6: tk = (a < b);
               3'd7: tk = (a >= b);
`endif
               default: tk = 0;
            endcase
            if (tk) npc = m_pc + bi;
         end
         7'h6f: begin
            wr = 1;
            res = m_pc + 4;
            npc = m_pc + ji;
         end
         7'h67: if (f3 == 0) begin
            wr = 1;
            res = m_pc + 4;
            npc = (a + ii) & 32'hFFFF_FFFE;
         end
         7'h37: begin wr = 1; res = ui; end
         7'h17: begin wr = 1; res = m_pc + ui; end
         default: ;
      endcase
      if (wr && rd != 0) m_rf[rd] = res;
      m_pc = npc;
   endtask

   function automatic logic [31:0] rand_instr();
      int c, rd, rs1, rs2, f3, imm, k;
      logic [31:0] w;
      c   = $urandom_range(0, 9);
      rd  = $urandom_range(0, 31);
      rs1 = $urandom_range(0, 31);
      rs2 = $urandom_range(0, 31);
      f3  = $urandom_range(0, 7);
      k   = $urandom_range(0, 5);
      case (c)
         0: return enc_r(k < 3 ? 0 : (k < 5 ? 32 : $urandom_range(0, 127)),
                         rs2, rs1, f3, rd);
         1: begin
            imm = $urandom_range(0, 4095);
            if (f3 == 1 || f3 == 5)
               imm[11:5] = (k < 3) ? 7'h00 : ((k < 5) ? 7'h20 : imm[11:5]);
            return enc_i(imm, rs1, f3, rd, 7'h13);
         end
         2: return enc_i($urandom_range(0, 63), 0, k == 0 ? f3 : 2, rd, 7'h03);
         3: return enc_s($urandom_range(0, 63), rs2, 0, k == 0 ? f3 : 2);
         4: begin
            imm = 4 * ($urandom_range(0, 32) - 16);
            return enc_b(imm, rs2, rs1, f3);
         end
         5: begin
            imm = 4 * ($urandom_range(0, 64) - 32);
            return enc_j(imm, rd);
         end
         6: return enc_i($urandom_range(0, 4095), rs1, k == 0 ? f3 : 0,
                         rd, 7'h67);
         7: return enc_u(20'($urandom), rd, 7'h37);
         8: return enc_u(20'($urandom), rd, 7'h17);
         default: begin
            // Keep loads away from never-written data words.
            w = $urandom;
            if (w[6:0] == 7'h03) w[6:0] = 7'h7f;
            return w;
         end
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;

      clear_prog();
      prog[0] = addi(1, 0, 10);
      prog[1] = addi(2, 0, 5);
      prog[2] = enc_r(0, 2, 1, 0, 3);
      prog[3] = enc_r(32, 2, 1, 0, 4);
      start_prog();
      check("reset_pc", dut.PC, 32'd0);
      check("reset_instr", dut.instr, prog[0]);
      check_reg(1, 32'd0);
      run(7);
      check_reg(1, 32'd10);
      check_reg(2, 32'd5);
      check_reg(3, 32'd15);
      check_reg(4, 32'd5);

      clear_prog();
      prog[0] = addi(1, 0, 100);
      prog[1] = enc_s(0, 1, 0, 2);
      prog[2] = enc_i(0, 0, 2, 2, 7'h03);
      prog[3] = addi(3, 2, 1);
      start_prog();
      run(6);
      check("dmem0", dut.DUT_Data.data_memory[0], 32'd100);
      check_reg(2, 32'd100);
      check_reg(3, 32'd101);

      clear_prog();
      prog[0] = addi(1, 0, 0);
      prog[1] = addi(2, 0, 5);
      prog[2] = addi(1, 1, 1);
      prog[3] = enc_b(-4, 2, 1, 1);
      start_prog();
      run(19);
      check_reg(1, 32'd5);
      check("loop_pc", dut.PC, 32'd44);

      clear_prog();
      prog[0] = enc_j(8, 1);
      prog[1] = addi(2, 0, 1);
      prog[2] = addi(3, 0, 2);
      start_prog();
      run(4);
      check_reg(1, 32'd4);
      check_reg(2, 32'd0);
      check_reg(3, 32'd2);

      clear_prog();
      prog[0] = addi(6, 0, 12);
      prog[1] = enc_i(1, 6, 0, 5, 7'h67);
      prog[2] = addi(2, 0, 1);
      prog[3] = addi(3, 0, 2);
      start_prog();
      run(5);
      check_reg(5, 32'd8);
      check_reg(3, 32'd2);
      check_reg(2, 32'd0);

      clear_prog();
      prog[0] = enc_u(20'h00001, 3, 7'h17);
      prog[1] = enc_u(20'h12345, 1, 7'h37);
      prog[2] = enc_u(20'hFFFFF, 2, 7'h37);
      prog[3] = enc_u(20'h00002, 4, 7'h17);
      start_prog();
      run(5);
      check_reg(1, 32'h1234_5000);
      check_reg(2, 32'hFFFF_F000);
      check_reg(3, 32'h0000_1000);
      check_reg(4, 32'h0000_200C);

      clear_prog();
      prog[0] = addi(0, 0, 7);
      prog[1] = enc_r(0, 0, 0, 0, 1);
      start_prog();
      run(3);
      check_reg(0, 32'd0);
      check_reg(1, 32'd0);

      clear_prog();
      prog[0]   = enc_j(1020, 0);
      prog[255] = addi(7, 7, 1);
      start_prog();
      run(4);
      check_reg(7, 32'd2);
      check("wrap_pc", dut.PC, 32'd2048);

      clear_prog();
      prog[0] = addi(1, 0, -1);
      prog[1] = enc_b(8, 0, 1, 4);
      prog[2] = addi(2, 0, 1);
      prog[3] = addi(3, 0, 1);
      start_prog();
      run(4);
`ifdef RV_FULL_BRANCH_EN
      check_reg(2, 32'd0);
`else
      check_reg(2, 32'd1);
`endif
      check_reg(3, 32'd1);

      clear_prog();
      prog[0] = addi(1, 0, 77);
      prog[1] = enc_s(8, 1, 0, 2);
      prog[2] = addi(2, 0, 0);
      prog[3] = addi(3, 0, 1000);
      prog[4] = addi(2, 2, 1);
      prog[5] = enc_s(12, 2, 0, 2);
      prog[6] = enc_b(-8, 3, 2, 1);
      start_prog();
      run(14);
      check_reg(2, 32'd4);
      check("pre_rst_pc", dut.PC, 32'd20);
      n_rst = 1'b1;
      @(negedge clk);
      n_rst = 1'b0;
      check("mid_rst_pc", dut.PC, 32'd0);
      for (int r = 0; r < 32; r++) check_reg(r, 32'd0);
      check("rst_dmem2", dut.DUT_Data.data_memory[2], 32'd77);
      check("rst_dmem3", dut.DUT_Data.data_memory[3], 32'd3);

      for (int i = 0; i < 256; i++) m_dm[i] = 0;
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 16; i++) prog[i] = enc_s(4 * i, 0, 0, 2);
         for (int i = 16; i < 256; i++) prog[i] = rand_instr();
         start_prog();
         f0 = n_fail;
         for (int s = 0; s < 300 && n_fail == f0; s++) begin
            run(1);
            model_step();
            check($sformatf("rand%0d_pc_s%0d", t, s), dut.PC, m_pc);
            for (int r = 0; r < 32; r++)
               check($sformatf("rand%0d_x%0d_s%0d", t, r, s),
                     dut.DUT_RF.RF[r], m_rf[r]);
         end
         for (int i = 0; i < 16; i++)
            check($sformatf("rand%0d_dmem%0d", t, i),
                  dut.DUT_Data.data_memory[i], m_dm[i]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
